// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding and
// the width of the wait-state counter.
package dmem_responder_pkg;

    localparam int WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage with a synchronous byte-enabled write port and a
// combinational read port sharing one word index. Contents are never reset.
module dmem_array #(
    parameter int DEPTH_WORDS = 64
) (
    input  logic                           clk,
    input  logic                           we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
    input  logic [31:0]                    wdata,
    input  logic [3:0]                     be,
    output logic [31:0]                    rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding load/store responder: accepts one request, waits a fixed
// number of cycles, performs the access and holds the response until taken.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_STATES);

    state_t                state;
    state_t                next_state;
    logic [WAIT_CNT_W-1:0] wait_cnt;

    logic        cap_we;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_be;

    logic        accept;
    logic        complete;
    logic        cur_we;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic [3:0]  cur_be;
    logic        cur_err;
    logic        mem_we;
    logic [31:0] mem_rdata;

    // With zero wait states the access happens on the acceptance edge, so the
    // live request inputs are used in IDLE and the captured copy otherwise.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        complete   = 1'b0;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        cur_we     = cap_we;
        cur_addr   = cap_addr;
        cur_wdata  = cap_wdata;
        cur_be     = cap_be;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                cur_we    = req_we;
                cur_addr  = req_addr;
                cur_wdata = req_wdata;
                cur_be    = req_be;
                if (req_valid) begin
                    accept = 1'b1;
                    if (WAIT_STATES == 0) begin
                        next_state = RESP;
                        complete   = 1'b1;
                    end else begin
                        next_state = WAIT;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt <= WAIT_CNT_W'(1)) begin
                    next_state = RESP;
                    complete   = 1'b1;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign cur_err = (cur_addr[1:0] != 2'b00) || (cur_addr[31:2] >= 30'(DEPTH_WORDS));
    assign mem_we  = complete && cur_we && !cur_err;

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .idx   (cur_addr[IDX_W+1:2]),
        .wdata (cur_wdata),
        .be    (cur_be),
        .rdata (mem_rdata)
    );

    // Response registers are loaded on the access edge and cleared once taken.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            cap_we    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_be    <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                cap_we    <= req_we;
                cap_addr  <= req_addr;
                cap_wdata <= req_wdata;
                cap_be    <= req_be;
                wait_cnt  <= WAIT_LOAD;
            end else if (state == WAIT && wait_cnt != '0) begin
                wait_cnt <= wait_cnt - WAIT_CNT_W'(1);
            end
            if (complete) begin
                rsp_err   <= cur_err;
                rsp_rdata <= (cur_err || cur_we) ? 32'h0 : mem_rdata;
            end else if (state == RESP && rsp_ready) begin
                rsp_err   <= 1'b0;
                rsp_rdata <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised self-checking bench for dmem_responder, with a word-array
// reference model and a second instance configured for zero wait states.
module tb_dmem_responder;

    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic rst_n;

    logic        a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_ready, a_rsp_err;
    logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;
    logic [3:0]  a_req_be;

    logic        z_req_valid, z_req_ready, z_req_we, z_rsp_valid, z_rsp_ready, z_rsp_err;
    logic [31:0] z_req_addr, z_req_wdata, z_rsp_rdata;
    logic [3:0]  z_req_be;

    int checks   = 0;
    int failures = 0;

    logic [31:0] model_mem [DEPTH];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(2)) dut (
        .clk(clk), .reset(rst_n),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_be(a_req_be),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
        .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(rst_n),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
        .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_be(z_req_be),
        .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
        .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
    );

    function automatic logic model_err(input logic [31:0] addr);
        return (addr % 4 != 0) || ((addr / 4) >= DEPTH);
    endfunction

    function automatic logic [31:0] be_mask(input logic [3:0] be);
        logic [31:0] m = 32'h0;
        for (int i = 0; i < 4; i++) if (be[i]) m = m | (32'hFF << (8 * i));
        return m;
    endfunction

    // One full transaction; returns what the responder produced and whether
    // the handshake rules (stability, ready/valid exclusivity) held throughout.
    task automatic do_txn(input bit z, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be, input int hold,
                          output logic [31:0] rd, output logic er, output int lat,
                          output bit hs_ok);
        int guard = 0;
        hs_ok = 1'b1;
        if (z) begin
            z_req_valid = 1; z_req_we = we; z_req_addr = addr; z_req_wdata = wdata; z_req_be = be;
        end else begin
            a_req_valid = 1; a_req_we = we; a_req_addr = addr; a_req_wdata = wdata; a_req_be = be;
        end
        while (!(z ? z_req_ready : a_req_ready) && guard < 20) begin
            @(posedge clk); #1; guard++;
        end
        if (guard >= 20) hs_ok = 1'b0;
        @(posedge clk); #1;
        if (z) begin
            z_req_valid = 0; z_req_we = ~we; z_req_addr = $urandom; z_req_wdata = $urandom; z_req_be = 4'($urandom);
        end else begin
            a_req_valid = 0; a_req_we = ~we; a_req_addr = $urandom; a_req_wdata = $urandom; a_req_be = 4'($urandom);
        end
        lat = 0;
        while (!(z ? z_rsp_valid : a_rsp_valid) && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        if (!(z ? z_rsp_valid : a_rsp_valid)) hs_ok = 1'b0;
        rd = z ? z_rsp_rdata : a_rsp_rdata;
        er = z ? z_rsp_err : a_rsp_err;
        if (z ? z_req_ready : a_req_ready) hs_ok = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if ((z ? z_req_ready : a_req_ready) || !(z ? z_rsp_valid : a_rsp_valid)) hs_ok = 1'b0;
            if ((z ? z_rsp_rdata : a_rsp_rdata) !== rd || (z ? z_rsp_err : a_rsp_err) !== er) hs_ok = 1'b0;
        end
        if (z) z_rsp_ready = 1; else a_rsp_ready = 1;
        @(posedge clk); #1;
        if (z) z_rsp_ready = 0; else a_rsp_ready = 0;
        if (!(z ? z_req_ready : a_req_ready) || (z ? z_rsp_valid : a_rsp_valid)) hs_ok = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        a_req_valid = 0; a_req_we = 0; a_req_addr = 0; a_req_wdata = 0; a_req_be = 0; a_rsp_ready = 0;
        z_req_valid = 0; z_req_we = 0; z_req_addr = 0; z_req_wdata = 0; z_req_be = 0; z_rsp_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (a_req_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_req_ready got=%b exp=1", a_req_ready); end
        checks++; if (a_rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_rsp_valid got=%b exp=0", a_rsp_valid); end
        checks++; if (a_rsp_rdata !== 32'h0) begin failures++; $display("[TB] FAIL reset_rsp_rdata got=%h exp=0", a_rsp_rdata); end
        checks++; if (a_rsp_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_rsp_err got=%b exp=0", a_rsp_err); end
        rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_store_load();
        logic [31:0] rd; logic er; int lat; bit ok;
        do_txn(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er, lat, ok);
        checks++; if (lat != 2) begin failures++; $display("[TB] FAIL store_latency got=%0d exp=2", lat); end
        checks++; if (er !== 1'b0 || rd !== 32'h0) begin failures++; $display("[TB] FAIL store_rsp got err=%b rd=%h exp err=0 rd=0", er, rd); end
        checks++; if (!ok) begin failures++; $display("[TB] FAIL store_handshake got=0 exp=1"); end
        do_txn(0, 0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat, ok);
        checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin failures++; $display("[TB] FAIL load_after_store got rd=%h err=%b exp rd=deadbeef err=0", rd, er); end
        checks++; if (!ok) begin failures++; $display("[TB] FAIL back_to_back_ready got=0 exp=1"); end
    endtask

    task automatic test_byte_enable();
        logic [31:0] rd; logic er; int lat; bit ok;
        do_txn(0, 1, 32'h10, 32'h00000055, 4'h1, 0, rd, er, lat, ok);
        do_txn(0, 0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat, ok);
        checks++; if (rd !== 32'hDEADBE55) begin failures++; $display("[TB] FAIL byte_enable got=%h exp=deadbe55", rd); end
        do_txn(0, 1, 32'h10, 32'h12345678, 4'h0, 0, rd, er, lat, ok);
        checks++; if (er !== 1'b0 || !ok) begin failures++; $display("[TB] FAIL be_zero_store got err=%b ok=%b exp err=0 ok=1", er, ok); end
        do_txn(0, 0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat, ok);
        checks++; if (rd !== 32'hDEADBE55) begin failures++; $display("[TB] FAIL be_zero_nochange got=%h exp=deadbe55", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat; bit ok;
        do_txn(0, 0, 32'h12, 32'h0, 4'h0, 0, rd, er, lat, ok);
        checks++; if (er !== 1'b1 || rd !== 32'h0) begin failures++; $display("[TB] FAIL misaligned_load got err=%b rd=%h exp err=1 rd=0", er, rd); end
        do_txn(0, 0, 32'h0, 32'h0, 4'h0, 0, rd, er, lat, ok);
        do_txn(0, 0, 32'(4 * DEPTH), 32'h0, 4'h0, 0, rd, er, lat, ok);
        checks++; if (er !== 1'b1 || rd !== 32'h0) begin failures++; $display("[TB] FAIL range_load got err=%b rd=%h exp err=1 rd=0", er, rd); end
        do_txn(0, 1, 32'h0, 32'hA5A5A5A5, 4'hF, 0, rd, er, lat, ok);
        do_txn(0, 1, 32'h12, 32'hFFFFFFFF, 4'hF, 0, rd, er, lat, ok);
        checks++; if (er !== 1'b1) begin failures++; $display("[TB] FAIL misaligned_store_err got=%b exp=1", er); end
        do_txn(0, 1, 32'(4 * DEPTH), 32'hFFFFFFFF, 4'hF, 0, rd, er, lat, ok);
        checks++; if (er !== 1'b1) begin failures++; $display("[TB] FAIL range_store_err got=%b exp=1", er); end
        do_txn(0, 0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat, ok);
        checks++; if (rd !== 32'hDEADBE55) begin failures++; $display("[TB] FAIL misaligned_store_nowrite got=%h exp=deadbe55", rd); end
        do_txn(0, 0, 32'h0, 32'h0, 4'h0, 0, rd, er, lat, ok);
        checks++; if (rd !== 32'hA5A5A5A5) begin failures++; $display("[TB] FAIL range_store_nowrite got=%h exp=a5a5a5a5", rd); end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd; logic er; int lat; bit ok;
        do_txn(0, 0, 32'h10, 32'h0, 4'h0, 5, rd, er, lat, ok);
        checks++; if (!ok) begin failures++; $display("[TB] FAIL backpressure_stable got=0 exp=1"); end
        checks++; if (rd !== 32'hDEADBE55) begin failures++; $display("[TB] FAIL backpressure_data got=%h exp=deadbe55", rd); end
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd; logic er; int lat; bit ok;
        do_txn(0, 1, 32'h20, 32'h11111111, 4'hF, 0, rd, er, lat, ok);
        a_req_valid = 1; a_req_we = 1; a_req_addr = 32'h20; a_req_wdata = 32'h22222222; a_req_be = 4'hF;
        @(posedge clk); #1;
        a_req_valid = 0;
        @(posedge clk); #1;
        checks++; if (a_rsp_valid !== 1'b0 || a_req_ready !== 1'b0) begin failures++; $display("[TB] FAIL abort_in_wait got valid=%b ready=%b exp 0 0", a_rsp_valid, a_req_ready); end
        rst_n = 0;
        #1;
        checks++; if (a_req_ready !== 1'b1 || a_rsp_valid !== 1'b0 || a_rsp_rdata !== 32'h0 || a_rsp_err !== 1'b0)
            begin failures++; $display("[TB] FAIL abort_reset_outputs got ready=%b valid=%b rd=%h err=%b exp 1 0 0 0", a_req_ready, a_rsp_valid, a_rsp_rdata, a_rsp_err); end
        repeat (3) @(posedge clk);
        #1; rst_n = 1;
        @(posedge clk); #1;
        do_txn(0, 0, 32'h20, 32'h0, 4'h0, 0, rd, er, lat, ok);
        checks++; if (rd !== 32'h11111111) begin failures++; $display("[TB] FAIL abort_no_write got=%h exp=11111111", rd); end
        do_txn(0, 0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat, ok);
        checks++; if (rd !== 32'hDEADBE55) begin failures++; $display("[TB] FAIL storage_survives_reset got=%h exp=deadbe55", rd); end
    endtask

    task automatic test_zero_wait();
        logic [31:0] rd; logic er; int lat; bit ok;
        do_txn(1, 1, 32'h8, 32'hCAFEF00D, 4'hF, 0, rd, er, lat, ok);
        checks++; if (lat != 0 || !ok) begin failures++; $display("[TB] FAIL zero_wait_store got lat=%0d ok=%b exp lat=0 ok=1", lat, ok); end
        do_txn(1, 0, 32'h8, 32'h0, 4'h0, 2, rd, er, lat, ok);
        checks++; if (lat != 0 || rd !== 32'hCAFEF00D || er !== 1'b0)
            begin failures++; $display("[TB] FAIL zero_wait_load got lat=%0d rd=%h err=%b exp lat=0 rd=cafef00d err=0", lat, rd, er); end
    endtask

    task automatic test_random();
        logic [31:0] rd, addr, wdata, exp_rd; logic er, we, exp_er; logic [3:0] be; int lat, hold, kind; bit ok;
        int bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            wdata = $urandom;
            model_mem[i] = wdata;
            do_txn(0, 1, 32'(4 * i), wdata, 4'hF, 0, rd, er, lat, ok);
            if (er !== 1'b0 || !ok) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("[TB] FAIL random_init got bad=%0d exp=0", bad); end
        for (int n = 0; n < 80; n++) begin
            kind  = $urandom_range(0, 9);
            addr  = 32'(4 * $urandom_range(0, DEPTH - 1));
            if (kind == 0) addr = addr | 32'($urandom_range(1, 3));
            if (kind == 1) addr = 32'(4 * DEPTH) + (32'($urandom_range(0, 1000)) << 2);
            we    = 1'($urandom);
            wdata = $urandom;
            be    = 4'($urandom);
            hold  = $urandom_range(0, 3);
            exp_er = model_err(addr);
            exp_rd = 32'h0;
            if (!exp_er) begin
                if (we) model_mem[addr / 4] = (model_mem[addr / 4] & ~be_mask(be)) | (wdata & be_mask(be));
                else exp_rd = model_mem[addr / 4];
            end
            do_txn(0, we, addr, wdata, be, hold, rd, er, lat, ok);
            checks++;
            if (rd !== exp_rd || er !== exp_er || lat != 2 || !ok) begin
                failures++;
                $display("[TB] FAIL random_txn%0d we=%b addr=%h got rd=%h err=%b lat=%0d ok=%b exp rd=%h err=%b lat=2 ok=1",
                         n, we, addr, rd, er, lat, ok, exp_rd, exp_er);
            end
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_byte_enable();
        test_errors();
        test_backpressure();
        test_reset_abort();
        test_zero_wait();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
